collision_scheduler: RTL
========================

# collision_scheduler

Per-frame collision sequencer for the bird/wall game. It latches the bird bounding box on each frame tick and steps through the wall register file one wall per cycle. Each wall gets the inclusive overlap-and-outside-gap test, and any collision is recorded in a sticky game-over flag. It sits between the frame timer, the wall register file and the game-state FSM, and sequences the collision datapath so one comparator serves every wall.

## Interface
- NUM_WALLS, 4, walls scanned per frame (2..16)
- COORD_W, 8, coordinate width
- IDX_W, $clog2(NUM_WALLS), wall index width
- FLOOR_Y, 8'd119, floor row (used only with CHECK_FLOOR_EN)

- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse requesting a scan
- clear_hit  in  1  one-cycle pulse clearing the sticky hit
- bird_xleft, bird_xright, bird_ytop, bird_ybottom  in  COORD_W each  bird box, sampled on accepted frame_tick
- wall_idx  out  IDX_W  wall register file read address
- wall_xleft, wall_xright, wall_topy, wall_bottomy  in  COORD_W each  wall data for wall_idx, valid in the same cycle (combinational read)
- scan_busy  out  1  high while scanning
- scan_done  out  1  one-cycle pulse at scan end
- hit  out  1  sticky collision flag
- hit_idx  out  IDX_W  index of the first wall hit
- floor_hit  out  1  sticky floor/ceiling collision (0 without CHECK_FLOOR_EN)

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - frame_tick with hit==0 → latch the bird box into internal registers, set idx=0, go to SCAN.
  - frame_tick with hit==1 → go to DONE directly; no scan is run.
- SCAN:
  - wall_idx=idx.
  - Per-wall test: collide = (bx_r >= w_xl) && (bx_l <= w_xr) && ((by_t <= w_top) || (by_b >= w_bot)).
  - All compares are unsigned, inclusive and COORD_W wide.
  - collide=1 → next edge sets hit=1 and hit_idx=idx, then go to DONE (early abort).
  - Otherwise, idx==NUM_WALLS-1 → DONE; else idx+1.
- DONE: scan_done=1 for exactly this cycle, then IDLE.
- The latched bird box is used for the whole scan. Live bird inputs are ignored after frame_tick.
- frame_tick arriving in SCAN or DONE is dropped and not queued.
- clear_hit from any state clears hit, hit_idx and floor_hit on the next edge. It does not change the state.
- clear_hit and a collision in the same cycle: the collision wins (hit=1 next cycle).
- clear_hit and frame_tick in the same IDLE cycle: the clear applies, and the tick is treated as hit==0 (scan starts).
- wall_idx is held at 0 outside SCAN.

## Timing
- Reset values: state=IDLE, wall_idx=0, scan_busy=0, scan_done=0, hit=0, hit_idx=0, floor_hit=0, latched box=0.
- scan_busy is a registered output, high exactly for the cycles spent in SCAN.
- Full scan without a hit: frame_tick at cycle T → SCAN during T+1..T+NUM_WALLS → scan_done at T+NUM_WALLS+1.
- Hit on wall k: hit rises at T+k+2 together with scan_done; the scan lasts k+1 cycles.
- Minimum frame_tick spacing for a full scan is NUM_WALLS+2 cycles.
- resetn asserted mid-scan: immediate return to reset values; no scan_done pulse.

## Configuration
- CHECK_FLOOR_EN defined:
  - In the first SCAN cycle, (by_b >= FLOOR_Y) || (by_t == 0) sets floor_hit=1 and hit=1, with hit_idx=0, and goes to DONE. The floor check has priority over wall 0.
- CHECK_FLOOR_EN undefined: floor_hit is tied to 0 and FLOOR_Y is unused.

## Test plan
- NUM_WALLS=4, bird box (10,17,50,57); walls at x 30..40, 60..70, 90..100, 120..130, gap 40..80 → scan_busy high for 4 cycles, scan_done at T+5, hit=0.
- Same setup, but wall 2 moved to x 15..25 with gap 40..80 and the bird at y 35..42 → hit=1, hit_idx=2, scan_done at T+4, wall_idx never reaches 3.
- Edge touch: bird_xright=30 equals wall_xleft=30, and bird_ytop=40 equals wall_topy=40 → hit=1 (inclusive compares).
- frame_tick again at T+2 during SCAN → ignored, only one scan_done. frame_tick while hit=1 → scan_done the next cycle, wall_idx stays 0.
- clear_hit in the same cycle as a colliding wall → hit=1 afterwards. clear_hit and frame_tick together in IDLE → hit cleared and a scan starts.
- resetn pulsed low at T+2 mid-scan → all outputs 0 immediately, no scan_done. With CHECK_FLOOR_EN: bird_ybottom=119 → floor_hit=1, hit=1, scan_done at T+2.

Source files
------------

// File: rtl/collision_scheduler.sv
// collision_scheduler
//   Per-frame collision sequencer. On an accepted frame_tick the bird box is
//   latched and the wall register file is walked one wall per cycle through a
//   single comparator. The first colliding wall aborts the scan and sets a
//   sticky hit flag with the index of that wall.
//
//   Optional feature macro: CHECK_FLOOR_EN (floor/ceiling test on the first
//   scan cycle; without it floor_hit stays 0 and FLOOR_Y is unused).
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   frame_tick             one-cycle scan request (dropped while busy)
//   clear_hit              one-cycle clear of hit / hit_idx / floor_hit
//   bird_*                 bird bounding box, sampled on an accepted tick
//   wall_idx               wall register file read address (0 outside SCAN)
//   wall_*                 wall data for wall_idx, same-cycle read
//   scan_busy              registered, high for every SCAN cycle
//   scan_done              one-cycle pulse in the DONE state
//   hit, hit_idx           sticky collision flag and first hit wall
//   floor_hit              sticky floor/ceiling collision
module collision_scheduler #(
    parameter int                 NUM_WALLS = 4,
    parameter int                 COORD_W   = 8,
    parameter int                 IDX_W     = $clog2(NUM_WALLS),
    parameter logic [COORD_W-1:0] FLOOR_Y   = 8'd119
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               frame_tick,
    input  logic               clear_hit,
    input  logic [COORD_W-1:0] bird_xleft,
    input  logic [COORD_W-1:0] bird_xright,
    input  logic [COORD_W-1:0] bird_ytop,
    input  logic [COORD_W-1:0] bird_ybottom,
    output logic [IDX_W-1:0]   wall_idx,
    input  logic [COORD_W-1:0] wall_xleft,
    input  logic [COORD_W-1:0] wall_xright,
    input  logic [COORD_W-1:0] wall_topy,
    input  logic [COORD_W-1:0] wall_bottomy,
    output logic               scan_busy,
    output logic               scan_done,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_idx,
    output logic               floor_hit
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COORD_W-1:0] bxl_q, bxl_d, bxr_q, bxr_d, byt_q, byt_d, byb_q, byb_d;
    logic               hit_q, hit_d, floor_q, floor_d, busy_q;
    logic [IDX_W-1:0]   hidx_q, hidx_d;
    logic               collide, floor_col, last_wall;

    // Bird overlaps the wall column and is not fully inside the gap.
    assign collide = (bxr_q >= wall_xleft) && (bxl_q <= wall_xright) &&
                     ((byt_q <= wall_topy) || (byb_q >= wall_bottomy));
    assign last_wall = (idx_q == IDX_W'(NUM_WALLS - 1));

`ifdef CHECK_FLOOR_EN
    // idx is 0 only in the first SCAN cycle, so this fires once per scan.
    assign floor_col = (idx_q == '0) && ((byb_q >= FLOOR_Y) || (byt_q == '0));
`else
    logic unused_floor;
    assign unused_floor = ^FLOOR_Y;
    assign floor_col    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bxl_d   = bxl_q;
        bxr_d   = bxr_q;
        byt_d   = byt_q;
        byb_d   = byb_q;
        hit_d   = hit_q;
        hidx_d  = hidx_q;
        floor_d = floor_q;

        // Clear first so a same-cycle collision below overrides it.
        if (clear_hit) begin
            hit_d   = 1'b0;
            hidx_d  = '0;
            floor_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    if (hit_q && !clear_hit) begin
                        state_d = DONE;
                    end else begin
                        bxl_d   = bird_xleft;
                        bxr_d   = bird_xright;
                        byt_d   = bird_ytop;
                        byb_d   = bird_ybottom;
                        idx_d   = '0;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (floor_col) begin
                    hit_d   = 1'b1;
                    floor_d = 1'b1;
                    hidx_d  = '0;
                    idx_d   = '0;
                    state_d = DONE;
                end else if (collide) begin
                    hit_d   = 1'b1;
                    hidx_d  = idx_q;
                    idx_d   = '0;
                    state_d = DONE;
                end else if (last_wall) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            bxl_q   <= '0;
            bxr_q   <= '0;
            byt_q   <= '0;
            byb_q   <= '0;
            hit_q   <= 1'b0;
            hidx_q  <= '0;
            floor_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bxl_q   <= bxl_d;
            bxr_q   <= bxr_d;
            byt_q   <= byt_d;
            byb_q   <= byb_d;
            hit_q   <= hit_d;
            hidx_q  <= hidx_d;
            floor_q <= floor_d;
            busy_q  <= (state_d == SCAN);
        end
    end

    assign wall_idx  = idx_q;
    assign scan_busy = busy_q;
    assign scan_done = (state_q == DONE);
    assign hit       = hit_q;
    assign hit_idx   = hidx_q;
    assign floor_hit = floor_q;

endmodule
